// File: rtl/uart_tx_packer_pkg.sv
// Shared UART constants: packer FSM state encodings, the frame delimiter
// (also used by the receive-side framing), and a length-width helper.
package uart_tx_packer_pkg;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } pack_state_t;

    localparam logic [7:0] UART_DELIM = 8'h0A;

    // Width of a "length minus one" field for a buffer of n bytes, never below 1.
    function automatic int unsigned len_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_packer_byte_pack_buf.sv
// byte_pack_buf: byte buffer that writes at the current count, with clear
// and registered length-minus-one.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_wr_en      store i_wr_byte at index o_count and advance the count
//   i_wr_byte    byte to store
//   i_clear      zero buffer, count and length (wins over a write)
//   o_data       packed buffer, byte k at [8k+7:8k]
//   o_count      bytes held, 0..DATA_MAX_LEN
//   o_len_1      o_count-1 truncated, tracks the last write
module byte_pack_buf
    import uart_tx_packer_pkg::*;
#(
    parameter  int unsigned DATA_MAX_LEN = 32,
    localparam int unsigned LW           = len_width(DATA_MAX_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [7:0]                i_wr_byte,
    input  logic                      i_clear,
    output logic [DATA_MAX_LEN*8-1:0] o_data,
    output logic [LW:0]               o_count,
    output logic [LW-1:0]             o_len_1
);

    logic [DATA_MAX_LEN*8-1:0] r_data;
    logic [LW:0]               r_count;
    logic [LW-1:0]             r_len_1;
    logic                      w_room;

    assign w_room = (r_count < (LW+1)'(DATA_MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
            r_len_1 <= '0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_count <= '0;
            r_len_1 <= '0;
        end else if (i_wr_en && w_room) begin
            // Decoded write keeps the byte lanes as plain muxes.
            for (int unsigned i = 0; i < DATA_MAX_LEN; i++) begin
                if (r_count == (LW+1)'(i)) begin
                    r_data[8*i +: 8] <= i_wr_byte;
                end
            end
            r_count <= r_count + (LW+1)'(1);
            // New count minus one is the old count.
            r_len_1 <= r_count[LW-1:0];
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_len_1 = r_len_1;

endmodule

// File: rtl/uart_tx_packer.sv
// uart_tx_packer: packs a valid/ready byte stream into the UART_tx
// multi-byte buffer and pulses send on delimiter, full buffer or flush,
// then holds the buffer until UART_tx has gone busy and returned idle.
// Ports:
//   clk, res     clock, async active-high reset
//   in_data      producer byte; in_valid qualifies it; in_ready = FILL state
//   flush        send a partially filled buffer (ignored when empty or busy)
//   data, len_1  buffer and byte-count-minus-one to UART_tx
//   send         one-cycle start pulse to UART_tx
//   tx_ready     UART_tx idle
module uart_tx_packer
    import uart_tx_packer_pkg::*;
#(
    parameter  int unsigned DATA_MAX_LEN = 32,
    parameter  logic [7:0]  DELIM        = UART_DELIM,
    parameter  bit          DELIM_EN     = 1'b1,
    localparam int unsigned LW           = len_width(DATA_MAX_LEN)
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [DATA_MAX_LEN*8-1:0] data,
    output logic [LW-1:0]             len_1,
    output logic                      send,
    input  logic                      tx_ready
);

    pack_state_t r_state;
    logic        r_in_ready;
    logic        r_send;

    logic        w_accept;
    logic        w_clear;
    logic        w_trigger;
    logic [LW:0] w_count;
    logic [LW:0] w_count_next;

    // in_ready is high exactly in FILL, so it also qualifies the accept.
    assign w_accept     = r_in_ready && in_valid;
    assign w_count_next = w_count + (LW+1)'(w_accept);
    assign w_clear      = (r_state == ST_WAIT_HIGH) && tx_ready;

    // Trigger conditions evaluated on the count after this cycle's accept.
    assign w_trigger = (w_accept && ((DELIM_EN && (in_data == DELIM)) ||
                                     (w_count_next == (LW+1)'(DATA_MAX_LEN))))
                    || (flush && (w_count_next != '0));

    byte_pack_buf #(
        .DATA_MAX_LEN (DATA_MAX_LEN)
    ) u_buf (
        .clk       (clk),
        .rst       (res),
        .i_wr_en   (w_accept),
        .i_wr_byte (in_data),
        .i_clear   (w_clear),
        .o_data    (data),
        .o_count   (w_count),
        .o_len_1   (len_1)
    );

    // Control FSM; send is registered and only ever set while in SEND.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= ST_FILL;
            r_in_ready <= 1'b1;
            r_send     <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_trigger) begin
                        r_state    <= ST_SEND;
                        r_in_ready <= 1'b0;
                        r_send     <= tx_ready;
                    end
                end
                ST_SEND: begin
                    if (r_send) begin
                        r_send  <= 1'b0;
                        r_state <= ST_WAIT_LOW;
                    end else if (tx_ready) begin
                        r_send <= 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!tx_ready) begin
                        r_state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (tx_ready) begin
                        r_state    <= ST_FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_FILL;
                    r_in_ready <= 1'b1;
                    r_send     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign send     = r_send;

endmodule

// File: tb/tb_uart_tx_packer.sv
// Directed bench for uart_tx_packer with DATA_MAX_LEN=4. A small UART_tx
// model drops tx_ready one cycle after send and raises it 20 cycles later.
module tb_uart_tx_packer;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] data;
    logic [1:0]  len_1;
    logic        send;
    logic        tx_ready;

    logic [7:0]  nd_data = 8'h00;
    logic        nd_valid = 1'b0;
    logic        nd_in_ready;
    logic        nd_flush = 1'b0;
    logic [31:0] nd_out;
    logic [1:0]  nd_len_1;
    logic        nd_send;
    logic        nd_tx_ready = 1'b1;

    always #5 clk = ~clk;

    uart_tx_packer #(.DATA_MAX_LEN(4), .DELIM(8'h0A), .DELIM_EN(1'b1)) dut (
        .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .data(data), .len_1(len_1),
        .send(send), .tx_ready(tx_ready)
    );

    uart_tx_packer #(.DATA_MAX_LEN(4), .DELIM(8'h0A), .DELIM_EN(1'b0)) dut_nd (
        .clk(clk), .res(res), .in_data(nd_data), .in_valid(nd_valid),
        .in_ready(nd_in_ready), .flush(nd_flush), .data(nd_out), .len_1(nd_len_1),
        .send(nd_send), .tx_ready(nd_tx_ready)
    );

    // UART_tx model
    int unsigned mdl_cnt = 0;
    logic        mdl_rdy = 1'b1;
    logic        tx_force_low = 1'b0;

    always @(posedge clk) begin
        if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_rdy <= 1'b1;
        end else if (send) begin
            mdl_rdy <= 1'b0;
            mdl_cnt <= 20;
        end
    end

    assign tx_ready = mdl_rdy & ~tx_force_low;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  n;
        logic        flush_last;
        logic        flush_after;
        logic [1:0]  exp_len;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    // Called at a negedge; waits (bounded) for in_ready.
    task automatic wait_in_ready(input string name);
        for (int c = 0; c < 200 && !in_ready; c++) @(negedge clk);
        chk(name, 32'(in_ready), 32'd1);
    endtask

    // Called at a negedge after the trigger has been set up: expects exactly
    // one send with the given buffer, stable data, then return to FILL cleared.
    task automatic finish_frame(input string name, input logic [31:0] exp_data,
                                input logic [1:0] exp_len);
        int  pulses = 0;
        bit  seen = 1'b0;
        bit  stable = 1'b1;
        bit  done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) flush = 1'b0;
            if (send) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    chk({name, " data"}, data, exp_data);
                    chk({name, " len_1"}, 32'(len_1), 32'(exp_len));
                    chk({name, " in_ready@send"}, 32'(in_ready), 32'd0);
                end
            end
            if (seen && in_ready) begin
                done = 1'b1;
                break;
            end
            if (seen && data !== exp_data) stable = 1'b0;
        end
        flush = 1'b0;
        chk({name, " send pulses"}, 32'(pulses), 32'd1);
        chk({name, " data stable"}, 32'(stable), 32'd1);
        chk({name, " back to fill"}, 32'(done), 32'd1);
        chk({name, " cleared"}, data, 32'h0);
    endtask

    task automatic run_frame(input string name, input vec_t v);
        wait_in_ready({name, " idle"});
        for (int i = 0; i < int'(v.n); i++) begin
            in_valid = 1'b1;
            in_data  = v.bytes[8*i +: 8];
            flush    = v.flush_last && (i == int'(v.n) - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = v.flush_after;
        finish_frame(name, v.exp_data, v.exp_len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_send;
        int   c;
        vec_t v;

        tbl[0] = '{bytes:32'h000A6968, n:3'd3, flush_last:1'b0, flush_after:1'b0, exp_len:2'd2, exp_data:32'h000A6968};
        tbl[1] = '{bytes:32'h34333231, n:3'd4, flush_last:1'b0, flush_after:1'b0, exp_len:2'd3, exp_data:32'h34333231};
        tbl[2] = '{bytes:32'h00000041, n:3'd1, flush_last:1'b0, flush_after:1'b1, exp_len:2'd0, exp_data:32'h00000041};
        tbl[3] = '{bytes:32'h00006655, n:3'd2, flush_last:1'b1, flush_after:1'b0, exp_len:2'd1, exp_data:32'h00006655};
        tbl[4] = '{bytes:32'h0000000A, n:3'd1, flush_last:1'b0, flush_after:1'b0, exp_len:2'd0, exp_data:32'h0000000A};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst send", 32'(send), 32'd0);
        chk("rst data", data, 32'h0);
        chk("rst len_1", 32'(len_1), 32'd0);
        res = 1'b0;
        @(negedge clk);

        // Table of frames
        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

        // Flush with empty buffer is ignored
        wait_in_ready("eflush idle");
        n_send = 0;
        flush  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (send) n_send++;
        end
        flush = 1'b0;
        chk("eflush no send", 32'(n_send), 32'd0);
        chk("eflush in_ready", 32'(in_ready), 32'd1);

        // Full buffer with a fifth byte held until turnaround
        wait_in_ready("hold idle");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h31 + 8'(i);
            @(negedge clk);
        end
        in_data = 8'h35;
        chk("hold in_ready low", 32'(in_ready), 32'd0);
        chk("hold data", data, 32'h34333231);
        for (c = 0; c < 100 && !in_ready; c++) @(negedge clk);
        chk("hold released", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold byte0 next frame", data, 32'h00000035);
        v = '{bytes:32'h0000000A, n:3'd1, flush_last:1'b0, flush_after:1'b0, exp_len:2'd1, exp_data:32'h00000A35};
        run_frame("hold tail", v);

        // tx_ready low at the trigger
        wait_in_ready("txlow idle");
        tx_force_low = 1'b1;
        in_valid = 1'b1; in_data = 8'h68; @(negedge clk);
        in_data = 8'h0A; @(negedge clk);
        in_valid = 1'b0;
        n_send = 0;
        for (int k = 0; k < 5; k++) begin
            if (send) n_send++;
            @(negedge clk);
        end
        chk("txlow no send", 32'(n_send), 32'd0);
        chk("txlow in_ready", 32'(in_ready), 32'd0);
        chk("txlow data", data, 32'h00000A68);
        tx_force_low = 1'b0;
        finish_frame("txlow", 32'h00000A68, 2'd1);

        // Reset while waiting for UART_tx to finish
        wait_in_ready("rstwh idle");
        in_valid = 1'b1; in_data = 8'h41; @(negedge clk);
        in_valid = 1'b0; flush = 1'b1; @(negedge clk);
        flush = 1'b0;
        for (c = 0; c < 20 && !send; c++) @(negedge clk);
        chk("rstwh send seen", 32'(send), 32'd1);
        repeat (3) @(negedge clk);
        chk("rstwh tx busy", 32'(tx_ready), 32'd0);
        #2 res = 1'b1;
        #1;
        chk("rstwh in_ready", 32'(in_ready), 32'd1);
        chk("rstwh send", 32'(send), 32'd0);
        chk("rstwh data", data, 32'h0);
        chk("rstwh len_1", 32'(len_1), 32'd0);
        @(negedge clk);
        res = 1'b0;
        v = '{bytes:32'h00000077, n:3'd1, flush_last:1'b0, flush_after:1'b1, exp_len:2'd0, exp_data:32'h00000077};
        run_frame("post rst", v);

        // DELIM_EN=0: delimiter byte is plain data
        @(negedge clk);
        n_send = 0;
        for (int i = 0; i < 3; i++) begin
            nd_valid = 1'b1;
            nd_data  = (i == 0) ? 8'h0A : ((i == 1) ? 8'h11 : 8'h22);
            @(negedge clk);
            if (nd_send) n_send++;
        end
        chk("nodelim no send", 32'(n_send), 32'd0);
        chk("nodelim in_ready", 32'(nd_in_ready), 32'd1);
        nd_data = 8'h33;
        @(negedge clk);
        nd_valid = 1'b0;
        chk("nodelim send", 32'(nd_send), 32'd1);
        chk("nodelim data", nd_out, 32'h3322110A);
        chk("nodelim len_1", 32'(nd_len_1), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
